scan_display: RTL and testbench
===============================

# scan_display

Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It takes packed BCD digits from the timekeeping logic and scans one digit per refresh slot. It blanks for one cycle between digits to suppress ghosting, and blinks selected digits while the adjust mode is active. It sits between the stopwatch counter/adjust logic and the board's `seg`/`an` pins. It replaces the fixed 4-digit, unclocked display path.

## Interface
Parameters:
- `NUM_DIGITS`, default 4: digits scanned; must be ≥1.
- `REFRESH_DIV`, default 100000: clk cycles per scan slot; must be ≥2.
- `BLINK_DIV`, default 50000000: clk cycles per blink half-period; must be ≥1.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `digits`  in  4*NUM_DIGITS: packed BCD; digit k occupies bits [4k+3:4k]; digit 0 is rightmost.
- `adj`  in  1: adjust mode; enables blinking.
- `blink_mask`  in  NUM_DIGITS: bit k=1 means digit k blinks while `adj`=1.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low, registered.
- `an`  out  NUM_DIGITS: anodes, active-low, registered; at most one bit low at any time.

## Operation
- Counters:
  - `ref_cnt` is 0..REFRESH_DIV-1 and wraps.
  - At the terminal count, `idx` advances, with NUM_DIGITS-1 wrapping to 0.
  - `blink_cnt` is 0..BLINK_DIV-1; at the terminal count, `phase` toggles.
- Decode: values 0–9 map to the standard active-low patterns (0 = 7'b1000000, 8 = 7'b0000000, 9 = 7'b0010000). Values 10–15 map to blank, 7'b1111111.
- Output register, each cycle:
  - Guard slot: if `ref_cnt`==0 (first cycle of every slot), then `an`=all-1 and `seg`=7'b1111111.
  - Hidden digit: else if `adj` && `blink_mask[idx]` && `phase`==1, then `an`=all-1 and `seg`=7'b1111111.
  - Otherwise: `an`=~(1<<idx) and `seg`=decode(`digits[idx]`).
- Adjust entry: on an `adj` rising edge (`adj`=1 and previous `adj`=0), `blink_cnt` is cleared and `phase` is cleared, so the digit is visible for the first half-period. While `adj`=0, `blink_cnt` keeps running but has no visible effect.
- `digits` and `blink_mask` are sampled live every cycle. A change takes effect on the next output update with no holding.
- NUM_DIGITS=1: `idx` stays 0; the guard cycle still occurs every slot.

## Timing
- Reset values:
  - `seg`=7'b1111111 and `an`=all-1.
  - `idx`=0, `ref_cnt`=0, `blink_cnt`=0, `phase`=0, previous-`adj` register=0.
- First cycle after reset release: guard slot, with outputs blank.
- Second cycle after reset release: `an` low on bit 0, showing digit 0.
- Input-to-output latency is 1 clk: a change in `digits`, `adj` or `blink_mask` in cycle t is visible on `seg`/`an` at t+1.
- Slot lengths: each slot lasts REFRESH_DIV cycles, made of 1 guard cycle and REFRESH_DIV-1 lit cycles. A full scan lasts NUM_DIGITS·REFRESH_DIV cycles.
- Blink period is 2·BLINK_DIV cycles, with a 50 % duty cycle.
- Simultaneous events:
  - A `ref_cnt` wrap together with a `phase` toggle: both take effect in the same cycle.
  - An `adj` rising edge on a `blink_cnt` terminal cycle: the clear wins, so `phase`=0.
- `rst` asserted mid-scan: next cycle all state and outputs hold their reset values, regardless of other inputs.

## Structure
- `display_pkg` holds:
  - `SEG_BLANK` = 7'b1111111.
  - A function `seg_decode(logic [3:0]) -> logic [6:0]`.
  - Localparam helpers for counter widths ($clog2 of REFRESH_DIV, BLINK_DIV and NUM_DIGITS, each with a minimum of 1).
- One sub-module, `bcd7_decode`: a purely combinational wrapper around `seg_decode`. It is instantiated once, on the muxed digit, not per digit.
- `scan_display` top level: counters, adj edge detect, digit mux and output register.

## Test plan
Unless stated otherwise, the bench uses NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=16.

1. Reset then scan: `digits`=16'h1234 and `adj`=0.
   - Required: after release, `an` cycles guard→1110(seg=7'b0011001)×3→guard→1101(seg=7'b0110000)×3→…→0111(seg=7'b1111001). The pattern repeats every 16 cycles.
2. Invalid digit: `digits`=16'h00A0.
   - Required: during the digit 1 slot, `an`=1101 and `seg`=7'b1111111. Digits 0, 2 and 3 show 7'b1000000.
3. Blink: `adj` rises with `blink_mask`=4'b0011.
   - Required: digits 0–1 are lit for 16 cycles and blanked for 16 cycles, alternating. Digits 2–3 are never blanked.
   - Required: dropping `adj` mid-blank restores digits 0–1 on the next cycle.
4. Adj edge restart: raise `adj` 3 cycles before a `blink_cnt` terminal count.
   - Required: the blink phase still starts visible, with the first blank 16 cycles after the edge.
5. Mid-operation reset: assert `rst` for 1 cycle during the digit 2 slot.
   - Required: the next cycle shows `an`=1111 and `seg`=7'b1111111. After release, the scan restarts at digit 0 with a guard cycle.
6. Anode one-hot check: random `digits`/`adj`/`blink_mask` for 10k cycles.
   - Required: `an` never has more than one zero bit, and `an`=all-1 always coincides with `seg`=7'b1111111.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg: shared constants and helpers for the
// multiplexed 7-segment display path.
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Counter width with a floor of one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes blank.
  function automatic logic [6:0] seg_decode(
    input logic [3:0] v
  );
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd7_decode.sv
// bcd7_decode: combinational BCD to active-low
// seven-segment pattern.
module bcd7_decode
  import display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(bcd_i);

endmodule

// File: rtl/scan_display.sv
// scan_display: time-multiplexed N-digit common-anode
// driver with inter-digit guard blanking and blink.
module scan_display
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic                    adj,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int RW = cnt_w(REFRESH_DIV);
  localparam int BW = cnt_w(BLINK_DIV);
  localparam int IW = cnt_w(NUM_DIGITS);

  logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  logic                  phase_q, phase_d;
  logic                  adj_q;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic          ref_term, idx_last, adj_rise;
  logic          blk_term, ph_eff;
  logic [BW-1:0] cnt_eff;
  logic [3:0]    digit_sel;
  logic          mask_sel;
  logic [6:0]    dec_seg;

  always_comb begin
    digit_sel = '0;
    mask_sel  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        digit_sel = digits[4*k +: 4];
        mask_sel  = blink_mask[k];
      end
    end
  end

  bcd7_decode u_dec (
    .bcd_i (digit_sel),
    .seg_o (dec_seg)
  );

  assign ref_term = ref_cnt_q == RW'(REFRESH_DIV - 1);
  assign idx_last = idx_q == IW'(NUM_DIGITS - 1);
  assign adj_rise = adj & ~adj_q;

  // An adj rising edge restarts blink timing this very
  // cycle, so the digit stays visible for a full half-period.
  assign cnt_eff  = adj_rise ? '0 : blink_cnt_q;
  assign ph_eff   = adj_rise ? 1'b0 : phase_q;
  assign blk_term = cnt_eff == BW'(BLINK_DIV - 1);

  always_comb begin
    ref_cnt_d   = ref_term ? '0 : ref_cnt_q + 1'b1;
    idx_d       = idx_q;
    if (ref_term) begin
      idx_d = idx_last ? '0 : idx_q + 1'b1;
    end
    blink_cnt_d = blk_term ? '0 : cnt_eff + 1'b1;
    phase_d     = ph_eff ^ blk_term;

    if (ref_cnt_q == '0) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end else if (adj && mask_sel && ph_eff) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end else begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q   <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      adj_q       <= 1'b0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      ref_cnt_q   <= ref_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      adj_q       <= adj;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_scan_display.sv
// tb_scan_display: directed scan/blink/reset vectors with a
// queued scoreboard and a per-cycle output monitor.
module tb_scan_display;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         adj = 1'b0;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0] blink_mask = '0;
  logic [6:0]   seg;
  logic [N-1:0] an;

  scan_display #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLINK_DIV   (B)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .adj        (adj),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic [N-1:0] an;
    logic [6:0]   seg;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [6:0] tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  // t: cycles since reset release; te: cycle of last adj rise
  int t = 0;
  int te = 0;
  logic aprev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(
    input  int           tt,
    input  int           tedge,
    output logic [N-1:0] ea,
    output logic [6:0]   es
  );
    int pos;
    int d;
    logic hide;
    pos  = tt % R;
    d    = (tt / R) % N;
    hide = adj && blink_mask[d] && ((((tt - tedge) / B) % 2) == 1);
    ea   = '1;
    es   = 7'b1111111;
    if (pos != 0 && !hide) begin
      ea = ~(N'(1) << d);
      es = tab[digits[4*d +: 4]];
    end
  endfunction

  task automatic step(input string nm);
    exp_t e;
    if (rst) begin
      e.an  = '1;
      e.seg = 7'b1111111;
      t     = 0;
      te    = 0;
      aprev = 1'b0;
    end else begin
      if (adj && !aprev) te = t;
      expect_at(t, te, e.an, e.seg);
      t++;
      aprev = adj;
    end
    e.cyc  = cyc + 1;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d never checked",
               e.name, e.cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checks++;
      if (an !== e.an || seg !== e.seg) begin
        errors++;
        $display("FAIL %s @%0d: an=%b seg=%b, want an=%b seg=%b",
                 e.name, cyc, an, seg, e.an, e.seg);
      end
    end
    if (cyc > 0) begin
      checks++;
      if ($isunknown(an) || $countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot @%0d: an=%b, want at most one 0",
                 cyc, an);
      end
      if (an == '1) begin
        checks++;
        if (seg !== 7'b1111111) begin
          errors++;
          $display("FAIL dark_seg @%0d: seg=%b, want 1111111",
                   cyc, seg);
        end
      end
    end
  end

  initial begin
    repeat (3) step("reset");
    rst = 1'b0;

    digits = 16'h1234;
    repeat (32) step("scan");

    digits = 16'h00A0;
    repeat (16) step("invalid");

    digits     = 16'h1234;
    blink_mask = 4'b0011;
    adj        = 1'b1;
    repeat (52) step("blink");
    adj = 1'b0;
    repeat (8) step("unblink");

    while (((t - te) % B) != 12) step("idle");
    adj = 1'b1;
    repeat (40) step("restart");

    adj        = 1'b0;
    blink_mask = '0;
    digits     = 16'h5678;
    while (!(((t / R) % N) == 2 && (t % R) == 2))
      step("pre_rst");
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    repeat (12) step("post_rst");

    repeat (10000) begin
      digits     = 16'($urandom);
      blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) adj = ~adj;
      step("random");
    end

    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0",
               sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
